// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// cache_mem_arbiter : shares one single-beat memory bus between I$ fills and
//                     D$ fills / write-throughs, fixed priority + I starvation.
// Revision 1.0
// ============================================================================
`default_nettype none

module cache_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic              i_mem_rd,
  output logic [31:0]       i_mem_rdata,
  output logic              i_mem_valid,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic              d_mem_rd,
  input  logic              d_mem_wr,
  input  logic [31:0]       d_mem_wdata,
  input  logic [3:0]        d_mem_wstrb,
  output logic [31:0]       d_mem_rdata,
  output logic              d_mem_valid,
  output logic              d_mem_wr_done,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_rvalid,
  input  logic              bus_bvalid,
  output logic [1:0]        owner
);

  // State encoding doubles as the owner code.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_I_RD = 2'd1,
    S_D_RD = 2'd2,
    S_D_WR = 2'd3
  } state_t;

  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                we_q, we_d;
  logic                req_q, req_d;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^{i_mem_addr[1:0], d_mem_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      we_q     <= we_d;
      req_q    <= req_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    we_d          = we_q;
    req_d         = req_q;
    i_mem_valid   = 1'b0;
    d_mem_valid   = 1'b0;
    d_mem_wr_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_mem_rd && (starve_q == C_LIMIT)) begin
          state_d  = S_I_RD;
          addr_d   = {i_mem_addr[ADDR_W-1:2], 2'b00};
          wdata_d  = '0;
          wstrb_d  = '0;
          we_d     = 1'b0;
          req_d    = 1'b1;
          starve_d = '0;
        end else if (d_mem_wr || d_mem_rd) begin
          // Write beats read when both D requests are up.
          state_d = d_mem_wr ? S_D_WR : S_D_RD;
          addr_d  = {d_mem_addr[ADDR_W-1:2], 2'b00};
          wdata_d = d_mem_wr ? d_mem_wdata : 32'h0;
          wstrb_d = d_mem_wr ? d_mem_wstrb : 4'h0;
          we_d    = d_mem_wr;
          req_d   = 1'b1;
          if (i_mem_rd && (starve_q < C_LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (i_mem_rd) begin
          state_d  = S_I_RD;
          addr_d   = {i_mem_addr[ADDR_W-1:2], 2'b00};
          wdata_d  = '0;
          wstrb_d  = '0;
          we_d     = 1'b0;
          req_d    = 1'b1;
          starve_d = '0;
        end
        if (!i_mem_rd) begin
          starve_d = '0;
        end
      end
      S_I_RD: begin
        if (bus_rvalid) begin
          i_mem_valid = 1'b1;
          state_d     = S_IDLE;
          req_d       = 1'b0;
        end
      end
      S_D_RD: begin
        if (bus_rvalid) begin
          d_mem_valid = 1'b1;
          state_d     = S_IDLE;
          req_d       = 1'b0;
        end
      end
      S_D_WR: begin
        if (bus_bvalid) begin
          d_mem_wr_done = 1'b1;
          state_d       = S_IDLE;
          req_d         = 1'b0;
          we_d          = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_wstrb   = wstrb_q;
  assign owner       = state_q;
  assign i_mem_rdata = bus_rdata;
  assign d_mem_rdata = bus_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
// tb_cache_mem_arbiter : vector table plus scoreboarded corner-case sequences.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_mem_addr = '0;
  logic        i_mem_rd = 1'b0;
  logic [31:0] i_mem_rdata;
  logic        i_mem_valid;
  logic [31:0] d_mem_addr = '0;
  logic        d_mem_rd = 1'b0;
  logic        d_mem_wr = 1'b0;
  logic [31:0] d_mem_wdata = '0;
  logic [3:0]  d_mem_wstrb = '0;
  logic [31:0] d_mem_rdata;
  logic        d_mem_valid;
  logic        d_mem_wr_done;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata = '0;
  logic        bus_rvalid = 1'b0;
  logic        bus_bvalid = 1'b0;
  logic [1:0]  owner;

  cache_mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_addr(i_mem_addr), .i_mem_rd(i_mem_rd), .i_mem_rdata(i_mem_rdata),
    .i_mem_valid(i_mem_valid),
    .d_mem_addr(d_mem_addr), .d_mem_rd(d_mem_rd), .d_mem_wr(d_mem_wr),
    .d_mem_wdata(d_mem_wdata), .d_mem_wstrb(d_mem_wstrb),
    .d_mem_rdata(d_mem_rdata), .d_mem_valid(d_mem_valid),
    .d_mem_wr_done(d_mem_wr_done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid), .bus_bvalid(bus_bvalid), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  typedef struct {
    logic        irq, drq, dwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          waits;
    logic [1:0]  exp_owner;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] o, input logic [31:0] a, input logic we,
                      input logic [3:0] s, input logic [31:0] wd, input logic [31:0] rd,
                      input int w);
    exp_t e;
    e.owner = o; e.addr = a; e.we = we; e.wstrb = s; e.wdata = wd; e.rdata = rd; e.waits = w;
    sb.push_back(e);
  endtask

  // Requests are already driven; one transaction is granted, answered and retired.
  task automatic serve();
    exp_t e;
    int   n;
    if (sb.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
      return;
    end
    e = sb.pop_front();
    tick();
    chk("req_latency", {31'h0, bus_req}, 32'h1);
    n = 0;
    while (!bus_req && n < 20) begin
      tick();
      n++;
    end
    if (!bus_req) return;
    chk("grant_owner", {30'h0, owner}, {30'h0, e.owner});
    chk("bus_addr", bus_addr, e.addr);
    chk("bus_we", {31'h0, bus_we}, {31'h0, e.we});
    chk("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, e.wstrb});
    if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
    for (int i = 0; i < e.waits; i++) begin
      tick();
      chk("wait_hold_req", {31'h0, bus_req}, 32'h1);
      chk("wait_hold_addr", bus_addr, e.addr);
      chk("wait_no_pulse", {29'h0, i_mem_valid, d_mem_valid, d_mem_wr_done}, 32'h0);
    end
    bus_rdata = e.rdata;
    if (e.we) bus_bvalid = 1'b1;
    else      bus_rvalid = 1'b1;
    #1;
    chk("resp_pulses", {29'h0, i_mem_valid, d_mem_valid, d_mem_wr_done},
        {29'h0, e.owner == 2'd1, e.owner == 2'd2, e.owner == 2'd3});
    if (e.owner == 2'd1) chk("i_rdata", i_mem_rdata, e.rdata);
    if (e.owner == 2'd2) chk("d_rdata", d_mem_rdata, e.rdata);
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    bus_bvalid = 1'b0;
    chk("req_drop", {31'h0, bus_req}, 32'h0);
    chk("owner_idle", {30'h0, owner}, 32'h0);
  endtask

  task automatic drop_all();
    i_mem_rd = 1'b0;
    d_mem_rd = 1'b0;
    d_mem_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'hDEAD_BEEF, 1,
                2'd1, 32'h0000_1004, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_2003, 32'h1111_1111, 4'b1000, 32'h0, 0,
                2'd3, 32'h0000_2000, 1'b1, 4'b1000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_3006, 32'hFFFF_FFFF, 4'hF, 32'hCAFE_F00D, 2,
                2'd2, 32'h0000_3004, 1'b0, 4'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_4001, 32'hA5A5_5A5A, 4'b0011, 32'h0, 0,
                2'd3, 32'h0000_4000, 1'b1, 4'b0011};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 32'h1234_5678, 0,
                2'd1, 32'hFFFF_FFFC, 1'b0, 4'h0};

    // Reset state
    repeat (3) tick();
    chk("rst_outputs", {27'h0, bus_req, bus_we, i_mem_valid, d_mem_valid, d_mem_wr_done}, 32'h0);
    chk("rst_owner", {30'h0, owner}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_wstrb", {28'h0, bus_wstrb}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Single-transaction vectors
    for (int v = 0; v < 5; v++) begin
      i_mem_rd = vecs[v].irq;
      d_mem_rd = vecs[v].drq;
      d_mem_wr = vecs[v].dwr;
      if (vecs[v].irq) i_mem_addr = vecs[v].addr;
      else             d_mem_addr = vecs[v].addr;
      d_mem_wdata = vecs[v].wdata;
      d_mem_wstrb = vecs[v].wstrb;
      push(vecs[v].exp_owner, vecs[v].exp_addr, vecs[v].exp_we, vecs[v].exp_wstrb,
           vecs[v].wdata, vecs[v].rdata, vecs[v].waits);
      serve();
      drop_all();
    end
    tick();

    // All three requesters at once: write, then read, then I
    i_mem_addr = 32'h0000_9000; d_mem_addr = 32'h0000_8000;
    d_mem_wdata = 32'h2222_3333; d_mem_wstrb = 4'hF;
    i_mem_rd = 1'b1; d_mem_rd = 1'b1; d_mem_wr = 1'b1;
    push(2'd3, 32'h0000_8000, 1'b1, 4'hF, 32'h2222_3333, 32'h0, 0);
    push(2'd2, 32'h0000_8000, 1'b0, 4'h0, 32'h0, 32'h4444_5555, 0);
    push(2'd1, 32'h0000_9000, 1'b0, 4'h0, 32'h0, 32'h6666_7777, 0);
    serve(); d_mem_wr = 1'b0;
    serve(); d_mem_rd = 1'b0;
    serve(); i_mem_rd = 1'b0;
    tick();

    // Starvation override, two full rounds
    i_mem_addr = 32'h0000_5000; d_mem_addr = 32'h0000_6008;
    i_mem_rd = 1'b1; d_mem_rd = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        push(2'd2, 32'h0000_6008, 1'b0, 4'h0, 32'h0, 32'h6000_0000 + k, 0);
      push(2'd1, 32'h0000_5000, 1'b0, 4'h0, 32'h0, 32'h5000_0000 + r, 1);
    end
    repeat (10) serve();
    drop_all();
    tick();

    // Stray responses in idle and in a D read, plus request withdrawal
    bus_rvalid = 1'b1; bus_bvalid = 1'b1;
    #1;
    chk("stray_idle_pulses", {29'h0, i_mem_valid, d_mem_valid, d_mem_wr_done}, 32'h0);
    tick();
    bus_rvalid = 1'b0; bus_bvalid = 1'b0;
    chk("stray_idle_owner", {30'h0, owner}, 32'h0);
    d_mem_addr = 32'h0000_7000; d_mem_rd = 1'b1;
    tick();
    chk("stray_grant_owner", {30'h0, owner}, 32'h2);
    d_mem_rd = 1'b0;
    bus_bvalid = 1'b1;
    #1;
    chk("stray_bvalid_pulses", {29'h0, i_mem_valid, d_mem_valid, d_mem_wr_done}, 32'h0);
    tick();
    bus_bvalid = 1'b0;
    chk("stray_still_busy", {29'h0, bus_req, owner}, {29'h0, 1'b1, 2'd2});
    bus_rdata = 32'h0BAD_F00D; bus_rvalid = 1'b1;
    #1;
    chk("withdrawn_completes", {29'h0, i_mem_valid, d_mem_valid, d_mem_wr_done}, 32'h2);
    chk("withdrawn_rdata", d_mem_rdata, 32'h0BAD_F00D);
    tick();
    bus_rvalid = 1'b0;
    chk("withdrawn_idle", {29'h0, bus_req, owner}, 32'h0);

    // Reset during a D read with starve count built up to the limit
    i_mem_addr = 32'h0000_5000; d_mem_addr = 32'h0000_6008;
    i_mem_rd = 1'b1; d_mem_rd = 1'b1;
    for (int k = 0; k < 3; k++)
      push(2'd2, 32'h0000_6008, 1'b0, 4'h0, 32'h0, 32'h7000_0000 + k, 0);
    repeat (3) serve();
    tick();
    chk("pre_reset_owner", {30'h0, owner}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("async_reset_req", {31'h0, bus_req}, 32'h0);
    chk("async_reset_owner", {30'h0, owner}, 32'h0);
    tick();
    bus_rvalid = 1'b1;
    #1;
    chk("reset_stray_pulses", {29'h0, i_mem_valid, d_mem_valid, d_mem_wr_done}, 32'h0);
    tick();
    bus_rvalid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++)
      push(2'd2, 32'h0000_6008, 1'b0, 4'h0, 32'h0, 32'h8000_0000 + k, 0);
    push(2'd1, 32'h0000_5000, 1'b0, 4'h0, 32'h0, 32'h8888_0000, 0);
    repeat (5) serve();
    drop_all();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one word-wide memory bus port between the instruction cache (read-only line fills) and the data cache (line-fill reads plus write-buffer write-throughs).
- Sits between the two caches and the AXI bridge.
- Runs one outstanding single-beat transaction at a time.
- Priority is fixed (D-write > D-read > I-read), with a starvation override for the I-side.

Parameters:
- ADDR_W, 32, address width on all ports.
- STARVE_LIMIT, 4, consecutive D-side grants allowed while i_mem_rd is pending before the I-side is forced in (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_mem_addr  in  ADDR_W  I-cache fill word address.
- i_mem_rd  in  1  I-cache read request, level, held until i_mem_valid.
- i_mem_rdata  out  32  read data to I-cache.
- i_mem_valid  out  1  one-cycle pulse, I read complete.
- d_mem_addr  in  ADDR_W  D-cache address; may be byte-unaligned on writes.
- d_mem_rd  in  1  D-cache fill read request, level.
- d_mem_wr  in  1  D-cache write-through request, level.
- d_mem_wdata  in  32  write data, already lane-aligned.
- d_mem_wstrb  in  4  byte strobes.
- d_mem_rdata  out  32  read data to D-cache.
- d_mem_valid  out  1  one-cycle pulse, D read complete.
- d_mem_wr_done  out  1  one-cycle pulse, D write complete.
- bus_req  out  1  transaction request to bridge, held until response.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  word-aligned address.
- bus_wdata  out  32  write data.
- bus_wstrb  out  4  write strobes; 0 on reads.
- bus_rdata  in  32  read data.
- bus_rvalid  in  1  read response pulse.
- bus_bvalid  in  1  write response pulse.
- owner  out  2  current grant: 0 none, 1 I-read, 2 D-read, 3 D-write (perf/debug).

Behaviour:
- FSM states: S_IDLE, S_I_RD, S_D_RD, S_D_WR. Reset and default go to S_IDLE.
- Reset values: all outputs, address/data/strobe latches and starve_cnt are 0.
- Arbitration, evaluated only in S_IDLE:
  - If starve_cnt == STARVE_LIMIT and i_mem_rd: grant I.
  - Else d_mem_wr → S_D_WR.
  - Else d_mem_rd → S_D_RD.
  - Else i_mem_rd → S_I_RD.
  - Else stay in S_IDLE.
  - If d_mem_rd and d_mem_wr are both high, the write wins.
- Grant cycle: the selected requester's addr, wdata and wstrb are latched. bus_addr = latched addr with bits [1:0] forced to 0. bus_wstrb = 0 for reads.
- Latency:
  - Request seen in S_IDLE at cycle N → bus_req = 1 from N+1.
  - bus_req, bus_we, bus_addr, bus_wdata and bus_wstrb are driven only from registers and stay stable while in a busy state.
- Completion:
  - S_I_RD: bus_rvalid → i_mem_valid = 1 in the same cycle (combinational), then S_IDLE at the next edge.
  - S_D_RD: bus_rvalid → d_mem_valid = 1, same timing.
  - S_D_WR: bus_bvalid → d_mem_wr_done = 1, same timing.
  - bus_req drops at the edge that returns the FSM to S_IDLE.
- Throughput: zero-wait slave gives 1 beat per 2 cycles. The requester's still-asserted request in the response cycle is not re-granted until the following S_IDLE cycle.
- Read data: i_mem_rdata and d_mem_rdata both carry bus_rdata unconditionally. Only the valid pulse of the owning side fires.
- Stray responses are discarded (no pulse to either side):
  - bus_rvalid or bus_bvalid in S_IDLE.
  - bus_bvalid in a read state.
  - bus_rvalid in S_D_WR.
- Request withdrawal mid-transaction (requester drops its request line) does not abort. The transaction completes and its pulse is still issued.
- Starvation counter:
  - On each D grant with i_mem_rd high: starve_cnt increments, saturating at STARVE_LIMIT.
  - On an I grant, or any S_IDLE cycle with i_mem_rd low: starve_cnt clears to 0.
- Reset mid-transaction: asynchronous return to S_IDLE with bus_req = 0 immediately. The bridge shares rst_n, so no response is expected afterwards. Any response that does arrive is a stray and is discarded.
- owner: 0 in S_IDLE; 1, 2 or 3 in S_I_RD, S_D_RD and S_D_WR respectively.

Test Plan:
1. I-read only: i_mem_rd = 1, i_mem_addr = 0x0000_1004; slave returns rdata 0xDEADBEEF with one wait cycle → bus_req high cycles 1–2, bus_addr = 0x1004, bus_we = 0, i_mem_valid pulses at cycle 2 with 0xDEADBEEF, d_mem_valid stays 0.
2. Unaligned write: d_mem_wr = 1, addr 0x2003, wdata 0x11111111, wstrb 4'b1000 → bus_addr = 0x2000, bus_wstrb = 4'b1000, bus_we = 1; bus_bvalid → d_mem_wr_done single pulse; owner = 3 during the transaction.
3. Simultaneous requests: d_mem_wr, d_mem_rd and i_mem_rd all high at the same cycle, zero-wait slave → grant order D-write, then D-read (after d_mem_wr drops), then I.
4. Starvation: D reads and I reads held continuously, STARVE_LIMIT = 4 → grant sequence D, D, D, D, I, D, D, D, D, I.
5. Stray responses: bus_rvalid pulsed in S_IDLE and bus_bvalid pulsed in S_D_RD → no valid or wr_done pulse on either side; FSM waits in S_D_RD until bus_rvalid arrives.
6. Reset mid-read: assert rst_n = 0 during S_D_RD → bus_req = 0 and owner = 0 immediately, starve_cnt = 0; after release, a new request is granted normally.
